// File: rtl/axi4_lite_slave_regs.sv
// rtl/axi4_lite_slave_regs.sv - AXI4-Lite responder over a bank of word-addressed registers
module axi4_lite_slave_regs #(
    parameter int                      DATA_WIDTH = 32,
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           awvalid,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    output logic                           awready,
    input  logic                           wvalid,
    input  logic [DATA_WIDTH-1:0]          wdata,
    output logic                           wready,
    output logic                           bvalid,
    output logic [1:0]                     bresp,
    input  logic                           bready,
    input  logic                           arvalid,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    output logic                           arready,
    output logic                           rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned SPAN  = NUM_REGS * 4;

    localparam logic [0:0] WS_ADDRDATA = 1'b0;
    localparam logic [0:0] WS_RESP     = 1'b1;
    localparam logic [0:0] RS_IDLE     = 1'b0;
    localparam logic [0:0] RS_DATA     = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the span test.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (off < ADDR_WIDTH'(SPAN)) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    logic [0:0]            ws_q, ws_d, rs_q, rs_d;
    logic                  aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
    logic [ADDR_WIDTH-1:0] awaddr_lat_q, awaddr_lat_d;
    logic [DATA_WIDTH-1:0] wdata_lat_q, wdata_lat_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_hs, w_hs, ar_hs;
    logic [ADDR_WIDTH-1:0] cm_addr;
    logic [DATA_WIDTH-1:0] cm_data;

    assign aw_hs   = awvalid && awready_q;
    assign w_hs    = wvalid && wready_q;
    assign ar_hs   = arvalid && arready_q;
    assign cm_addr = aw_hs ? awaddr : awaddr_lat_q;
    assign cm_data = w_hs ? wdata : wdata_lat_q;

    always_comb begin
        ws_d         = ws_q;
        aw_cap_d     = aw_cap_q;
        w_cap_d      = w_cap_q;
        awaddr_lat_d = awaddr_lat_q;
        wdata_lat_d  = wdata_lat_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        regs_d       = regs_q;
        case (ws_q)
            WS_ADDRDATA: begin
                if (aw_hs) begin
                    aw_cap_d     = 1'b1;
                    awaddr_lat_d = awaddr;
                end
                if (w_hs) begin
                    w_cap_d     = 1'b1;
                    wdata_lat_d = wdata;
                end
                // Both halves present only on the edge that completes the second handshake.
                if (aw_cap_d && w_cap_d) begin
                    if (addr_ok(cm_addr)) regs_d[addr_idx(cm_addr)] = cm_data;
                    bresp_d  = addr_ok(cm_addr) ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d = 1'b1;
                    ws_d     = WS_RESP;
                end
            end
            default: begin
                if (bvalid_q && bready) begin
                    bvalid_d = 1'b0;
                    aw_cap_d = 1'b0;
                    w_cap_d  = 1'b0;
                    ws_d     = WS_ADDRDATA;
                end
            end
        endcase
        awready_d = (ws_d == WS_ADDRDATA) && !aw_cap_d;
        wready_d  = (ws_d == WS_ADDRDATA) && !w_cap_d;
    end

    // Reads sample regs_q, so a read accepted on a commit edge sees the old value.
    always_comb begin
        rs_d     = rs_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rs_q)
            RS_IDLE: begin
                if (ar_hs) begin
                    rdata_d  = addr_ok(araddr) ? regs_q[addr_idx(araddr)] : '0;
                    rresp_d  = addr_ok(araddr) ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d = 1'b1;
                    rs_d     = RS_DATA;
                end
            end
            default: begin
                if (rvalid_q && rready) begin
                    rvalid_d = 1'b0;
                    rs_d     = RS_IDLE;
                end
            end
        endcase
        arready_d = (rs_d == RS_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_q         <= WS_ADDRDATA;
            rs_q         <= RS_IDLE;
            aw_cap_q     <= 1'b0;
            w_cap_q      <= 1'b0;
            awaddr_lat_q <= '0;
            wdata_lat_q  <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            ws_q         <= ws_d;
            rs_q         <= rs_d;
            aw_cap_q     <= aw_cap_d;
            w_cap_q      <= w_cap_d;
            awaddr_lat_q <= awaddr_lat_d;
            wdata_lat_q  <= wdata_lat_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
endmodule
